// File: rtl/reward_scheduler_if.sv
// Request/launch/acknowledge bundle between the node control FSMs, the
// reward scheduler and the reward (packet packer) block.
interface reward_scheduler_if #(
  parameter int WORD_WIDTH = 16,
  parameter int NUM_REQ    = 6
);
  logic                  en;
  logic [NUM_REQ-1:0]    req;
  logic [WORD_WIDTH-1:0] inv_hops;
  logic [WORD_WIDTH-1:0] reward_done;
  logic                  reward_en;
  logic [WORD_WIDTH-1:0] pkt_type;
  logic [NUM_REQ-1:0]    grant;
  logic                  busy;
  logic [NUM_REQ-1:0]    ack;
  logic                  ack_dropped;
  logic                  ack_timeout;
  logic [WORD_WIDTH-1:0] drop_cnt;
  logic [WORD_WIDTH-1:0] timeout_cnt;

  modport master (
    output en, req, inv_hops, reward_done,
    input  reward_en, pkt_type, grant, busy, ack, ack_dropped, ack_timeout,
           drop_cnt, timeout_cnt
  );

  modport slave (
    input  en, req, inv_hops, reward_done,
    output reward_en, pkt_type, grant, busy, ack, ack_dropped, ack_timeout,
           drop_cnt, timeout_cnt
  );
endinterface

// File: rtl/reward_scheduler.sv
// Round-robin scheduler that sequences packet-packing jobs from the node's
// six requesters onto the single reward block, with INV hop filter and watchdog.
module reward_scheduler #(
  parameter int WORD_WIDTH   = 16,
  parameter int NUM_REQ      = 6,
  parameter int MAX_INV_HOPS = 4,
  parameter int WDOG_CYCLES  = 1024
) (
  input  logic              clk,
  input  logic              nrst,
  reward_scheduler_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [WORD_WIDTH-1:0] WDOG_LAST = WORD_WIDTH'(WDOG_CYCLES - 2);
  localparam logic [WORD_WIDTH-1:0] HOP_LIMIT = WORD_WIDTH'(MAX_INV_HOPS);
  localparam logic [IDX_W-1:0]      INV_IDX   = IDX_W'(1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DONE, DROP} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      rr_ptr, win, win_sel;
  logic                  win_found;
  int unsigned           pos;
  logic [NUM_REQ-1:0]    grant;
  logic [WORD_WIDTH-1:0] pkt_type, wdog, drop_cnt, timeout_cnt;
  logic                  to_flag;
  logic                  launch_req, inv_drop, done_hit, wdog_hit;
  logic                  reward_en, busy, ack_dropped, ack_timeout;
  logic [NUM_REQ-1:0]    ack;

  function automatic logic [WORD_WIDTH-1:0] pkt_code(input logic [IDX_W-1:0] idx);
    case (int'(idx))
      0:       return WORD_WIDTH'(1);
      1:       return WORD_WIDTH'(3);
      2:       return WORD_WIDTH'(4);
      3:       return WORD_WIDTH'(5);
      4:       return WORD_WIDTH'(3);
      5:       return WORD_WIDTH'(6);
      default: return '0;
    endcase
  endfunction

  function automatic logic [WORD_WIDTH-1:0] sat_inc(input logic [WORD_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] ptr_next(input logic [IDX_W-1:0] idx);
    return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
  endfunction

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_sel   = rr_ptr;
    win_found = 1'b0;
    pos       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = int'(rr_ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!win_found && bus.req[IDX_W'(pos)]) begin
        win_sel   = IDX_W'(pos);
        win_found = 1'b1;
      end
    end
  end

  assign launch_req = bus.en && win_found;
  assign inv_drop   = (win_sel == INV_IDX) && (bus.inv_hops >= HOP_LIMIT);
  assign done_hit   = bus.reward_done[0];
  assign wdog_hit   = (wdog == WDOG_LAST);

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    reward_en   = 1'b0;
    busy        = 1'b1;
    ack         = '0;
    ack_dropped = 1'b0;
    ack_timeout = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (launch_req) state_nxt = inv_drop ? DROP : LAUNCH;
      end
      LAUNCH: begin
        reward_en = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (done_hit || wdog_hit) state_nxt = DONE;
      end
      DONE: begin
        ack         = grant;
        ack_timeout = to_flag;
        state_nxt   = IDLE;
      end
      DROP: begin
        ack         = grant;
        ack_dropped = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job context, watchdog and statistics; completion wins over a same-cycle expiry.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      rr_ptr      <= '0;
      win         <= '0;
      grant       <= '0;
      pkt_type    <= '0;
      wdog        <= '0;
      to_flag     <= 1'b0;
      drop_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch_req) begin
            win      <= win_sel;
            grant    <= NUM_REQ'(1) << win_sel;
            pkt_type <= pkt_code(win_sel);
            to_flag  <= 1'b0;
          end
        end
        LAUNCH: wdog <= '0;
        WAIT: begin
          if (!done_hit) begin
            wdog <= wdog + 1'b1;
            if (wdog_hit) begin
              to_flag     <= 1'b1;
              timeout_cnt <= sat_inc(timeout_cnt);
            end
          end
        end
        DONE, DROP: begin
          rr_ptr   <= ptr_next(win);
          grant    <= '0;
          pkt_type <= '0;
          if (state == DROP) drop_cnt <= sat_inc(drop_cnt);
        end
        default: ;
      endcase
    end
  end

  assign bus.reward_en   = reward_en;
  assign bus.pkt_type    = pkt_type;
  assign bus.grant       = grant;
  assign bus.busy        = busy;
  assign bus.ack         = ack;
  assign bus.ack_dropped = ack_dropped;
  assign bus.ack_timeout = ack_timeout;
  assign bus.drop_cnt    = drop_cnt;
  assign bus.timeout_cnt = timeout_cnt;

endmodule

// File: tb/tb_reward_scheduler.sv
// Bench for reward_scheduler: directed scenarios plus randomized jobs checked
// against a transaction-level round-robin model.
module tb_reward_scheduler;
  localparam int WW   = 16;
  localparam int NR   = 6;
  localparam int MAXH = 4;
  localparam int WDOG = 1024;

  logic clk;
  logic nrst;
  int   checks   = 0;
  int   failures = 0;
  int   m_rr, m_drop, m_to;

  reward_scheduler_if #(.WORD_WIDTH(WW), .NUM_REQ(NR)) bus ();

  reward_scheduler #(
    .WORD_WIDTH(WW), .NUM_REQ(NR), .MAX_INV_HOPS(MAXH), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_pick(input logic [5:0] r, input int p);
    for (int i = 0; i < NR; i++) begin
      if (r[(p + i) % NR]) return (p + i) % NR;
    end
    return 0;
  endfunction

  function automatic logic [15:0] exp_code(input int w);
    case (w)
      0: return 16'h0001;
      1: return 16'h0003;
      2: return 16'h0004;
      3: return 16'h0005;
      4: return 16'h0003;
      5: return 16'h0006;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    m_rr = 0; m_drop = 0; m_to = 0;
  endtask

  task automatic do_reset();
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    model_reset();
  endtask

  // Drives one job: presents r, waits for launch/drop, answers reward_done
  // dly cycles after LAUNCH (dly<0: never), records what the DUT did.
  task automatic do_job(input logic [5:0] r, input logic [15:0] hops, input int dly,
                        input int en_off_k, output logic [5:0] g, output logic [15:0] pt,
                        output logic [5:0] a, output logic drp, output logic tmo,
                        output int lw, output int lat, output int en_cnt);
    int k;
    bit started;
    logic [15:0] rnd;
    g = '0; pt = '0; a = '0; drp = 1'b0; tmo = 1'b0;
    lw = -1; lat = -1; en_cnt = 0; k = 0; started = 1'b0;
    bus.req = r;
    bus.inv_hops = hops;
    for (int c = 1; c <= WDOG + 40; c++) begin
      @(negedge clk);
      if (!started && bus.busy && (bus.reward_en || bus.ack_dropped)) begin
        started = 1'b1; lw = c; g = bus.grant; pt = bus.pkt_type;
      end
      if (started) begin
        k++;
        if (bus.reward_en) en_cnt++;
        if (k == en_off_k) bus.en = 1'b0;
        if (bus.ack != '0) begin
          a = bus.ack; drp = bus.ack_dropped; tmo = bus.ack_timeout; lat = k;
          break;
        end
        rnd = 16'($urandom);
        bus.reward_done = (dly >= 0 && k == dly + 1) ? (rnd | 16'h0001) : (rnd & 16'hFFFE);
      end
    end
    bus.reward_done = '0;
    bus.req = r & ~a;
  endtask

  task automatic test_reset();
    nrst = 1'b1; bus.en = 1'b0; bus.req = '0; bus.inv_hops = '0; bus.reward_done = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.grant !== '0) begin failures++; $display("FAIL reset_grant got=%b exp=0", bus.grant); end
    checks++; if (bus.pkt_type !== '0) begin failures++; $display("FAIL reset_pkt got=%h exp=0", bus.pkt_type); end
    checks++; if ({bus.ack, bus.ack_dropped, bus.ack_timeout, bus.reward_en} !== '0) begin
      failures++; $display("FAIL reset_ack got=%b/%b/%b/%b exp=0", bus.ack, bus.ack_dropped, bus.ack_timeout, bus.reward_en); end
    checks++; if ({bus.drop_cnt, bus.timeout_cnt} !== '0) begin
      failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.drop_cnt, bus.timeout_cnt); end
    nrst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    logic [5:0] g, a; logic [15:0] pt; logic drp, tmo; int lw, lat, enc;
    bus.en = 1'b1;
    do_job(6'b000001, 16'd0, 2, 0, g, pt, a, drp, tmo, lw, lat, enc);
    checks++; if (g !== 6'b000001) begin failures++; $display("FAIL single_grant got=%b exp=000001", g); end
    checks++; if (pt !== 16'h0001) begin failures++; $display("FAIL single_pkt got=%h exp=0001", pt); end
    checks++; if (a !== 6'b000001) begin failures++; $display("FAIL single_ack got=%b exp=000001", a); end
    checks++; if ({drp, tmo} !== 2'b00) begin failures++; $display("FAIL single_flags got=%b exp=00", {drp, tmo}); end
    checks++; if (lw !== 1) begin failures++; $display("FAIL single_launch_lat got=%0d exp=1", lw); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL single_ack_lat got=%0d exp=4", lat); end
    checks++; if (enc !== 1) begin failures++; $display("FAIL single_en_pulses got=%0d exp=1", enc); end
    m_rr = 1;
    @(negedge clk);
    checks++; if ({bus.busy, bus.grant, bus.pkt_type} !== '0) begin
      failures++; $display("FAIL single_idle got busy=%b grant=%b pkt=%h exp=0", bus.busy, bus.grant, bus.pkt_type); end
  endtask

  task automatic test_round_robin();
    logic [5:0] g, a, eg; logic [15:0] pt; logic drp, tmo; int lw, lat, enc, dly, w;
    do_reset();
    for (int j = 0; j < 7; j++) begin
      dly = $urandom_range(1, 5);
      do_job(6'h3f, 16'd2, dly, 0, g, pt, a, drp, tmo, lw, lat, enc);
      w = model_pick(6'h3f, m_rr);
      eg = 6'(1) << w;
      checks++; if (g !== eg) begin failures++; $display("FAIL rr_grant job%0d got=%b exp=%b", j, g, eg); end
      checks++; if (pt !== exp_code(w)) begin failures++; $display("FAIL rr_pkt job%0d got=%h exp=%h", j, pt, exp_code(w)); end
      checks++; if (a !== eg) begin failures++; $display("FAIL rr_ack job%0d got=%b exp=%b", j, a, eg); end
      checks++; if (lat !== dly + 2) begin failures++; $display("FAIL rr_ack_lat job%0d got=%0d exp=%0d", j, lat, dly + 2); end
      checks++; if (lw !== ((j == 0) ? 1 : 2)) begin failures++; $display("FAIL rr_gap job%0d got=%0d exp=%0d", j, lw, (j == 0) ? 1 : 2); end
      checks++; if ({drp, tmo, enc} !== {1'b0, 1'b0, 32'd1}) begin
        failures++; $display("FAIL rr_flags job%0d got=%b%b en=%0d exp=00 en=1", j, drp, tmo, enc); end
      m_rr = (w + 1) % NR;
    end
  endtask

  task automatic test_inv_drop();
    logic [5:0] g, a; logic [15:0] pt; logic drp, tmo; int lw, lat, enc;
    do_job(6'b000010, 16'd4, 2, 0, g, pt, a, drp, tmo, lw, lat, enc);
    checks++; if (a !== 6'b000010) begin failures++; $display("FAIL drop_ack got=%b exp=000010", a); end
    checks++; if ({drp, tmo} !== 2'b10) begin failures++; $display("FAIL drop_flags got=%b exp=10", {drp, tmo}); end
    checks++; if (enc !== 0) begin failures++; $display("FAIL drop_en_pulses got=%0d exp=0", enc); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL drop_lat got=%0d exp=1", lat); end
    m_drop++; m_rr = 2;
    @(negedge clk);
    checks++; if (bus.drop_cnt !== 16'(m_drop)) begin failures++; $display("FAIL drop_cnt got=%0d exp=%0d", bus.drop_cnt, m_drop); end
    do_job(6'b000010, 16'd3, 1, 0, g, pt, a, drp, tmo, lw, lat, enc);
    checks++; if (pt !== 16'h0003) begin failures++; $display("FAIL inv_ok_pkt got=%h exp=0003", pt); end
    checks++; if ({a, drp, tmo} !== {6'b000010, 2'b00}) begin failures++; $display("FAIL inv_ok_ack got=%b/%b%b exp=000010/00", a, drp, tmo); end
    checks++; if ({enc, lat} !== {32'd1, 32'd3}) begin failures++; $display("FAIL inv_ok_timing got en=%0d lat=%0d exp en=1 lat=3", enc, lat); end
    m_rr = 2;
  endtask

  task automatic test_timeout();
    logic [5:0] g, a; logic [15:0] pt; logic drp, tmo; int lw, lat, enc;
    do_job(6'b001000, 16'd0, -1, 0, g, pt, a, drp, tmo, lw, lat, enc);
    checks++; if (a !== 6'b001000) begin failures++; $display("FAIL to_ack got=%b exp=001000", a); end
    checks++; if ({drp, tmo} !== 2'b01) begin failures++; $display("FAIL to_flags got=%b exp=01", {drp, tmo}); end
    checks++; if (lat !== WDOG + 1) begin failures++; $display("FAIL to_lat got=%0d exp=%0d", lat - 1, WDOG); end
    checks++; if (pt !== 16'h0005) begin failures++; $display("FAIL to_pkt got=%h exp=0005", pt); end
    m_to++; m_rr = 4;
    @(negedge clk);
    checks++; if (bus.timeout_cnt !== 16'(m_to)) begin failures++; $display("FAIL to_cnt got=%0d exp=%0d", bus.timeout_cnt, m_to); end
  endtask

  task automatic test_reset_midjob();
    logic [5:0] g, a; logic [15:0] pt; logic drp, tmo; int lw, lat, enc;
    bus.req = 6'b100000;
    repeat (4) @(negedge clk);
    checks++; if ({bus.busy, bus.reward_en, bus.grant} !== {2'b10, 6'b100000}) begin
      failures++; $display("FAIL mid_wait got busy=%b en=%b grant=%b exp 1/0/100000", bus.busy, bus.reward_en, bus.grant); end
    #2 nrst = 1'b1;
    #1;
    checks++; if ({bus.busy, bus.grant, bus.pkt_type, bus.ack, bus.ack_dropped, bus.ack_timeout, bus.reward_en} !== '0) begin
      failures++; $display("FAIL mid_async got busy=%b grant=%b pkt=%h ack=%b exp=0", bus.busy, bus.grant, bus.pkt_type, bus.ack); end
    checks++; if ({bus.drop_cnt, bus.timeout_cnt} !== '0) begin
      failures++; $display("FAIL mid_cnt got=%0d/%0d exp=0/0", bus.drop_cnt, bus.timeout_cnt); end
    @(negedge clk);
    checks++; if (bus.ack !== '0) begin failures++; $display("FAIL mid_no_ack got=%b exp=0", bus.ack); end
    nrst = 1'b0;
    model_reset();
    do_job(6'b100000, 16'd0, 1, 0, g, pt, a, drp, tmo, lw, lat, enc);
    checks++; if (g !== 6'b100000) begin failures++; $display("FAIL relaunch_grant got=%b exp=100000", g); end
    checks++; if (pt !== 16'h0006) begin failures++; $display("FAIL relaunch_pkt got=%h exp=0006", pt); end
    checks++; if ({a, drp, tmo} !== {6'b100000, 2'b00}) begin failures++; $display("FAIL relaunch_ack got=%b/%b%b exp=100000/00", a, drp, tmo); end
    checks++; if ({lw, lat} !== {32'd1, 32'd3}) begin failures++; $display("FAIL relaunch_lat got=%0d/%0d exp=1/3", lw, lat); end
    m_rr = 0;
  endtask

  task automatic test_enable();
    logic [5:0] g, a; logic [15:0] pt; logic drp, tmo; int lw, lat, enc;
    logic seen;
    @(negedge clk);
    bus.en = 1'b0; bus.req = 6'b000100; seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | bus.busy | bus.reward_en | (|bus.grant);
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL en_off_idle got activity=%b exp=0", seen); end
    bus.en = 1'b1;
    do_job(6'b000100, 16'd0, 2, 2, g, pt, a, drp, tmo, lw, lat, enc);
    checks++; if (lw !== 1) begin failures++; $display("FAIL en_launch_lat got=%0d exp=1", lw); end
    checks++; if ({g, pt} !== {6'b000100, 16'h0004}) begin failures++; $display("FAIL en_grant got=%b/%h exp=000100/0004", g, pt); end
    checks++; if ({a, drp, tmo} !== {6'b000100, 2'b00}) begin failures++; $display("FAIL en_drop_ack got=%b/%b%b exp=000100/00", a, drp, tmo); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL en_drop_lat got=%0d exp=4", lat); end
    bus.en = 1'b1;
    m_rr = 3;
  endtask

  task automatic test_random();
    logic [5:0] g, a, r, eg; logic [15:0] pt, hops; logic drp, tmo, ed;
    int lw, lat, enc, dly, gap, w;
    for (int j = 0; j < 40; j++) begin
      gap = $urandom_range(0, 3);
      bus.req = '0;
      repeat (gap) @(negedge clk);
      r = 6'($urandom_range(1, 63));
      hops = 16'($urandom_range(0, 7));
      dly = $urandom_range(1, 6);
      do_job(r, hops, dly, 0, g, pt, a, drp, tmo, lw, lat, enc);
      w = model_pick(r, m_rr);
      eg = 6'(1) << w;
      ed = (w == 1) && (hops >= 16'(MAXH));
      checks++; if (g !== eg) begin failures++; $display("FAIL rnd_grant job%0d req=%b got=%b exp=%b", j, r, g, eg); end
      checks++; if (pt !== exp_code(w)) begin failures++; $display("FAIL rnd_pkt job%0d got=%h exp=%h", j, pt, exp_code(w)); end
      checks++; if (a !== eg) begin failures++; $display("FAIL rnd_ack job%0d got=%b exp=%b", j, a, eg); end
      checks++; if ({drp, tmo} !== {ed, 1'b0}) begin failures++; $display("FAIL rnd_flags job%0d got=%b exp=%b0", j, {drp, tmo}, ed); end
      checks++; if (lat !== (ed ? 1 : dly + 2)) begin failures++; $display("FAIL rnd_lat job%0d got=%0d exp=%0d", j, lat, ed ? 1 : dly + 2); end
      checks++; if (enc !== (ed ? 0 : 1)) begin failures++; $display("FAIL rnd_en job%0d got=%0d exp=%0d", j, enc, ed ? 0 : 1); end
      checks++; if (lw !== ((gap == 0) ? 2 : 1)) begin failures++; $display("FAIL rnd_gap job%0d got=%0d exp=%0d", j, lw, (gap == 0) ? 2 : 1); end
      if (ed) m_drop++;
      m_rr = (w + 1) % NR;
    end
    bus.req = '0;
    @(negedge clk);
    checks++; if (bus.drop_cnt !== 16'(m_drop)) begin failures++; $display("FAIL rnd_drop_cnt got=%0d exp=%0d", bus.drop_cnt, m_drop); end
    checks++; if (bus.timeout_cnt !== 16'(m_to)) begin failures++; $display("FAIL rnd_to_cnt got=%0d exp=%0d", bus.timeout_cnt, m_to); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_inv_drop();
    test_timeout();
    test_reset_midjob();
    test_enable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reward_scheduler.md
Name: reward_scheduler

Overview:
- Arbitrates the six packet-packing sources of a node onto the single reward (packet packer) block.
- Sequences each job: picks a winner, drives the packet type, pulses the reward enable, waits for completion, then acknowledges the requester.
- Sits between the node's control FSMs (HB/INV/MR handling, data forwarding, CH duties) and the reward block.
- Uses a round-robin policy with an INV hop-limit filter and a completion watchdog.

Parameters:
- WORD_WIDTH, 16, width of packet-type word, hop input and counters.
- NUM_REQ, 6, number of requesters (fixed index map below).
- MAX_INV_HOPS, 4, INV forward is packed only if inv_hops < MAX_INV_HOPS.
- WDOG_CYCLES, 1024, max cycles to wait for reward completion.

Ports:
- clk  in  1  clock, all logic on rising edge.
- nrst  in  1  reset, asynchronous, active-high (1 = reset).
- en  in  1  global enable; gates new arbitration only.
- req  in  NUM_REQ  level requests. Index map: 0 HB fwd, 1 INV fwd, 2 MR timeout, 3 data/SOS fwd, 4 CH INV, 5 CH timeslot.
- inv_hops  in  WORD_WIDTH  hopsFromCH of the received INV, valid while req[1] is high.
- reward_done  in  WORD_WIDTH  completion from the reward block; only bit 0 is used.
- reward_en  out  1  one-cycle launch pulse to the reward block.
- pkt_type  out  WORD_WIDTH  packet type for the granted job.
- grant  out  NUM_REQ  one-hot current job; 0 when idle.
- busy  out  1  high in every state except IDLE.
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse to the requester.
- ack_dropped  out  1  qualifies ack: job discarded, not packed.
- ack_timeout  out  1  qualifies ack: watchdog expired.
- drop_cnt  out  WORD_WIDTH  count of dropped INV jobs, saturating.
- timeout_cnt  out  WORD_WIDTH  count of watchdog expiries, saturating.

Behaviour:
- Reset: nrst=1 forces every output, rr_ptr and the watchdog counter to 0, and the state to IDLE, immediately. This aborts any in-flight job with no ack; requesters must re-request after reset.
- pkt_type codes by index:
  - 0 → 0x0001
  - 1 → 0x0003
  - 2 → 0x0004
  - 3 → 0x0005
  - 4 → 0x0003
  - 5 → 0x0006
- States: IDLE, LAUNCH, WAIT, DONE, DROP.
- IDLE:
  - If en=1 and req≠0, select the first set bit scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Register grant and pkt_type for the winner.
  - If the winner is 1 and inv_hops ≥ MAX_INV_HOPS → DROP, else → LAUNCH.
  - If en=0, stay in IDLE.
- LAUNCH: reward_en=1 for exactly this cycle; watchdog counter cleared; → WAIT.
- WAIT:
  - reward_en=0; watchdog counter increments each cycle.
  - reward_done[0]=1 → DONE with ack_timeout=0.
  - Counter reaching WDOG_CYCLES-1 without done → DONE with ack_timeout=1 and timeout_cnt+1.
  - reward_done during LAUNCH or IDLE is ignored.
- DONE:
  - ack = grant for one cycle; ack_timeout as set in WAIT.
  - rr_ptr = (winner+1) mod NUM_REQ; grant and pkt_type cleared on exit; → IDLE.
- DROP:
  - ack = grant, ack_dropped=1 for one cycle; no reward_en.
  - drop_cnt+1; rr_ptr advances as in DONE; → IDLE.
- Latency: req sampled in IDLE at cycle N → grant valid N+1 (LAUNCH, reward_en high) → earliest ack N+3 if reward_done arrives at N+2. Back-to-back jobs re-arbitrate after a one-cycle IDLE gap.
- Requesters hold req until their ack and deassert in the cycle after it. req changes outside IDLE have no effect on the current job.
- en dropping mid-job does not abort the job; it completes normally.
- Counters saturate at all-ones and never wrap.
- No back-pressure on ack; requester acceptance is implied.

Test Plan:
- Reset, then req=6'b000001, reward_done pulsed 2 cycles after reward_en → grant=000001, pkt_type=0x0001, ack=000001 with flags 0, rr_ptr=1, busy back to 0.
- req=6'b111111 held, each job completing, starting from rr_ptr=0 → grant order 0,1,2,3,4,5,0; pkt_types 0x0001,0x0003,0x0004,0x0005,0x0003,0x0006 (inv_hops=2).
- req[1]=1, inv_hops=4 → no reward_en, ack=000010 with ack_dropped=1, drop_cnt=1; repeat with inv_hops=3 → normal launch with pkt_type 0x0003.
- req[3]=1, reward_done never asserted → ack=001000 with ack_timeout=1 exactly WDOG_CYCLES cycles after LAUNCH; timeout_cnt=1.
- nrst asserted in WAIT with req[5] pending → all outputs 0 asynchronously, no ack; after release with req[5] held → job relaunches with grant=100000 and pkt_type 0x0006.
- en=0 with req=000100 → stays IDLE, busy=0; en=1 → launch next cycle; en dropped during WAIT → job still acks normally.
